bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one port of the dual-port block RAM between NUM_REQ requesters, e.g. Z80 CPU, ADAMnet DMA and the debug loader.
- Each requester uses a req/ack handshake.
- The arbiter serialises accesses, drives the RAM port with registered signals, and returns read data with a valid strobe.
- It accounts for the RAM's one-cycle registered read latency.

Parameters:
ADDR_W, 16, RAM address width; must match the RAM's address width.
DATA_W, 8, data width.
NUM_REQ, 3, number of requesters (2..8); index 0 is the CPU.

Ports:
clk_sys  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
req  in  NUM_REQ  per-requester access request; level-sensitive.
we  in  NUM_REQ  per-requester write enable; 1 = write, 0 = read.
addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
wdata  in  NUM_REQ*DATA_W  packed write data, same packing as addr.
ack  out  NUM_REQ  one-cycle completion pulse per requester.
rdata  out  DATA_W  registered read data; valid while ack[i] is high for a read.
busy  out  1  high whenever the state is not IDLE.
mem_addr  out  ADDR_W  to the RAM port address.
mem_data  out  DATA_W  to the RAM port write data.
mem_wren  out  1  to the RAM port write enable.
mem_q  in  DATA_W  RAM port read data.

Behaviour:
- Reset values: ack=0, rdata=0, busy=0, mem_addr=0, mem_data=0, mem_wren=0, state=IDLE, rr_ptr=0.
- Reset is asynchronous. Asserting it mid-access abandons the access: no ack is issued and mem_wren drops immediately. A write already clocked into the RAM is not undone.
- State machine, states IDLE, ISSUE, WAIT, DONE:
  - IDLE: if any req bit is high, select a winner g.
    - Latch addr[g] into mem_addr and wdata[g] into mem_data.
    - mem_wren <= we[g] & req[g]; remember g and we[g].
    - Go to ISSUE.
  - ISSUE (RAM samples the port on this edge):
    - mem_wren <= 0.
    - If write: ack[g] <= 1, go to DONE.
    - If read: go to WAIT.
  - WAIT: mem_q is valid this cycle; rdata <= mem_q, ack[g] <= 1, go to DONE.
  - DONE: ack <= 0, rr_ptr <= g+1 (wraps to 0 at NUM_REQ), go to IDLE.
- Resulting latency, counted from req sampled high in IDLE at edge 0:
  - Write: ack high in the cycle after edge 1.
  - Read: ack and rdata high in the cycle after edge 2.
- Peak throughput: one write per 3 cycles, one read per 4 cycles.
- Round-robin grant: search starts at rr_ptr and takes the first set req bit in ascending index order, wrapping modulo NUM_REQ.
- Handshake rules:
  - addr, wdata and we are sampled only at grant; later changes are ignored.
  - A requester must drop req in the cycle ack is high, or it is treated as a new request in IDLE. DONE guarantees one cycle of separation.
  - Dropping req before ack does not cancel a granted access; the ack is still issued.
  - At most one ack bit is high in any cycle.
- rdata holds its last value until the next read completes; it is not updated on writes.
- No request bits set: remain in IDLE with all outputs unchanged, except mem_wren = 0.

Optional Feature:
- Macro: BRAM_ARB_CPU_PRIORITY_EN.
- Defined: requester 0 wins whenever req[0] is high in IDLE, regardless of rr_ptr. Remaining requesters rotate round-robin among themselves; rr_ptr skips index 0.
- Undefined: pure round-robin across all NUM_REQ requesters, as above.

Test Plan:
- Single read: RAM preloaded with 0x5A at 0x0123; req[1]=1, we=0, addr=0x0123 from IDLE → ack[1] pulses 3 cycles after the sampling edge, rdata=0x5A, mem_wren never high.
- Write then read: requester 0 writes 0xC3 to 0x7FFF; ack[0] pulses 2 cycles after sampling → requester 0 reads 0x7FFF and gets rdata=0xC3.
- Contention: req[2:0]=3'b111 held, each req dropped on its ack and re-raised on the next cycle → grant order 0,1,2,0,1,2; no two ack bits ever high together; no requester starved.
- Wrap: rr_ptr=2 with req=3'b101 → requester 2 granted first, then 0.
- Reset mid-read: assert reset in WAIT → ack=0, busy=0, mem_wren=0 asynchronously; after release a fresh request completes normally with correct data.
- With BRAM_ARB_CPU_PRIORITY_EN: req=3'b111 held continuously (req[0] re-raised after each ack) → requester 0 wins every arbitration; with req[0]=0, requesters 1 and 2 alternate.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Requester-side handshake and RAM-port bundle for bram_port_arbiter.
// The arbiter binds the slave modport; the requesters/RAM side binds master.
interface bram_port_arbiter_if #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      busy;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data;
    logic                      mem_wren;
    logic [DATA_W-1:0]         mem_q;

    modport master (
        output req, we, addr, wdata, mem_q,
        input  ack, rdata, busy, mem_addr, mem_data, mem_wren
    );

    modport slave (
        input  req, we, addr, wdata, mem_q,
        output ack, rdata, busy, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read BRAM port between NUM_REQ requesters.
// Define BRAM_ARB_CPU_PRIORITY_EN to give requester 0 absolute priority over the others.
module bram_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 3
) (
    input  logic               clk_sys,
    input  logic               reset,
    bram_port_arbiter_if.slave bus
);
    localparam int unsigned N     = NUM_REQ;
    localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt;
    logic             gnt_we;
    logic [PTR_W-1:0] pick;
    logic             found;

    always_comb begin
        logic [PTR_W-1:0] cand;
        int unsigned      base;
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        base  = 0;
`ifdef BRAM_ARB_CPU_PRIORITY_EN
        if (bus.req[0]) begin
            found = 1'b1;
        end else begin
            // rr_ptr ranges over 1..N-1 here; 0 (reset value) means start at 1
            base = (rr_ptr == '0) ? 0 : int'(rr_ptr) - 1;
            for (int unsigned off = 0; off < N - 1; off++) begin
                cand = PTR_W'(1 + ((base + off) % (N - 1)));
                if (!found && bus.req[cand]) begin
                    pick  = cand;
                    found = 1'b1;
                end
            end
        end
`else
        base = int'(rr_ptr);
        for (int unsigned off = 0; off < N; off++) begin
            cand = PTR_W'((base + off) % N);
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gnt          <= '0;
            gnt_we       <= 1'b0;
            bus.ack      <= '0;
            bus.rdata    <= '0;
            bus.busy     <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_data <= '0;
            bus.mem_wren <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.mem_wren <= 1'b0;
                    if (found) begin
                        bus.mem_addr <= bus.addr[int'(pick)*ADDR_W +: ADDR_W];
                        bus.mem_data <= bus.wdata[int'(pick)*DATA_W +: DATA_W];
                        bus.mem_wren <= bus.we[pick] & bus.req[pick];
                        gnt          <= pick;
                        gnt_we       <= bus.we[pick];
                        bus.busy     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_wren <= 1'b0;
                    if (gnt_we) begin
                        bus.ack[gnt] <= 1'b1;
                        state        <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    bus.rdata    <= bus.mem_q;
                    bus.ack[gnt] <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    bus.ack  <= '0;
                    bus.busy <= 1'b0;
`ifdef BRAM_ARB_CPU_PRIORITY_EN
                    // CPU grants leave the rotation among the others untouched
                    if (gnt != '0)
                        rr_ptr <= (int'(gnt) == NUM_REQ - 1) ? PTR_W'(1) : gnt + 1'b1;
`else
                    rr_ptr <= (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a behavioural registered-read RAM.
// Expected grant orders follow BRAM_ARB_CPU_PRIORITY_EN when it is defined.
module tb_bram_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NR = 3;

    typedef struct {
        int         idx;
        bit         rd;
        logic [7:0] data;
        int         at;
    } exp_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR)) bus ();

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    exp_t       sb[$];
    exp_t       e;
    logic [7:0] shadow [int];
    logic [7:0] ram [0:65535];
    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;
    bit         wren_seen;
    int         ord_i [6];
    int         ord_k [6];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input bit rd, input logic [15:0] a,
                        input logic [7:0] d, input int at);
        exp_t x;
        x.idx = i;
        x.rd  = rd;
        x.at  = at;
        if (rd) begin
            x.data = shadow.exists(int'(a)) ? shadow[int'(a)] : pat(a);
        end else begin
            x.data          = d;
            shadow[int'(a)] = d;
        end
        sb.push_back(x);
    endtask

    task automatic run_req(input int i, input int n, input bit wr,
                           input logic [15:0] a0, input logic [7:0] d0);
        bit got;
        for (int k = 0; k < n; k++) begin
            bus.we[i]                = wr;
            bus.addr[i*AW +: AW]     = a0 + 16'(k);
            bus.wdata[i*DW +: DW]    = d0 + 8'(k);
            bus.req[i]               = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk_sys);
                got = bus.ack[i];
            end
            if (!got) check("ack_timeout", 32'(bus.ack[i]), 1);
            bus.req[i] = 1'b0;
            @(negedge clk_sys);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    // Registered-read RAM on the arbitrated port
    always @(posedge clk_sys) begin
        if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
        bus.mem_q <= ram[bus.mem_addr];
    end

    always @(posedge clk_sys) cycle <= cycle + 1;

    always @(negedge clk_sys) begin
        if (!reset && bus.mem_wren) wren_seen = 1'b1;
        if (!reset && bus.ack != '0) begin
            check("ack_onehot", 32'($onehot(bus.ack)), 1);
            check("busy_on_ack", 32'(bus.busy), 1);
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(bus.ack), 0);
            end else begin
                e = sb.pop_front();
                check("ack_who", 32'(bus.ack), 32'(1) << e.idx);
                if (e.rd) check("rdata", 32'(bus.rdata), 32'(e.data));
                if (e.at >= 0) check("ack_latency", cycle, e.at);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        for (int a = 0; a < 65536; a++) ram[a] = pat(16'(a));
        ram[16'h0123]    = 8'h5A;
        shadow[16'h0123] = 8'h5A;

        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_rdata", 32'(bus.rdata), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_data", 32'(bus.mem_data), 0);
        check("rst_mem_wren", 32'(bus.mem_wren), 0);
        reset = 1'b0;
        @(negedge clk_sys);

        // single read
        wren_seen = 1'b0;
        push(1, 1, 16'h0123, 8'h00, cycle + 3);
        run_req(1, 1, 1'b0, 16'h0123, 8'h00);
        check("read_no_wren", 32'(wren_seen), 0);

        // write then read back
        push(0, 0, 16'h7FFF, 8'hC3, cycle + 2);
        run_req(0, 1, 1'b1, 16'h7FFF, 8'hC3);
        push(0, 1, 16'h7FFF, 8'h00, cycle + 3);
        run_req(0, 1, 1'b0, 16'h7FFF, 8'h00);

        // a write leaves rdata alone; idle keeps the port registers
        push(2, 0, 16'h0040, 8'h11, cycle + 2);
        run_req(2, 1, 1'b1, 16'h0040, 8'h11);
        repeat (3) @(negedge clk_sys);
        check("rdata_hold", 32'(bus.rdata), 32'h00C3);
        check("idle_addr_hold", 32'(bus.mem_addr), 32'h0040);
        check("idle_data_hold", 32'(bus.mem_data), 32'h0011);
        check("idle_wren", 32'(bus.mem_wren), 0);
        check("idle_busy", 32'(bus.busy), 0);

        // contention: all three requesters, two reads each
        do_reset();
`ifdef BRAM_ARB_CPU_PRIORITY_EN
        ord_i = '{0, 0, 1, 2, 1, 2};
        ord_k = '{0, 1, 0, 0, 1, 1};
`else
        ord_i = '{0, 1, 2, 0, 1, 2};
        ord_k = '{0, 0, 0, 1, 1, 1};
`endif
        for (int j = 0; j < 6; j++)
            push(ord_i[j], 1, 16'h1000 + 16'(16 * ord_i[j]) + 16'(ord_k[j]), 8'h00, -1);
        fork
            run_req(0, 2, 1'b0, 16'h1000, 8'h00);
            run_req(1, 2, 1'b0, 16'h1010, 8'h00);
            run_req(2, 2, 1'b0, 16'h1020, 8'h00);
        join

        // wrap: grant 1 leaves rr_ptr at 2, then requesters 0 and 2 collide
        do_reset();
        push(1, 1, 16'h0300, 8'h00, cycle + 3);
        run_req(1, 1, 1'b0, 16'h0300, 8'h00);
`ifdef BRAM_ARB_CPU_PRIORITY_EN
        push(0, 1, 16'h0400, 8'h00, -1);
        push(2, 1, 16'h0420, 8'h00, -1);
`else
        push(2, 1, 16'h0420, 8'h00, -1);
        push(0, 1, 16'h0400, 8'h00, -1);
`endif
        fork
            run_req(0, 1, 1'b0, 16'h0400, 8'h00);
            run_req(2, 1, 1'b0, 16'h0420, 8'h00);
        join

        // reset during WAIT of a read
        bus.we[1]            = 1'b0;
        bus.addr[1*AW +: AW] = 16'h0200;
        bus.req[1]           = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("busy_in_wait", 32'(bus.busy), 1);
        reset = 1'b1;
        #1;
        check("rst_async_ack", 32'(bus.ack), 0);
        check("rst_async_busy", 32'(bus.busy), 0);
        check("rst_async_wren", 32'(bus.mem_wren), 0);
        bus.req[1] = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        push(1, 1, 16'h0123, 8'h00, cycle + 3);
        run_req(1, 1, 1'b0, 16'h0123, 8'h00);

        // reset while the write strobe is on the port: the write never lands
        bus.we[0]            = 1'b1;
        bus.addr[0*AW +: AW] = 16'h0500;
        bus.wdata[0*DW +: DW] = 8'hEE;
        bus.req[0]           = 1'b1;
        @(negedge clk_sys);
        check("wren_in_issue", 32'(bus.mem_wren), 1);
        reset = 1'b1;
        #1;
        check("rst_async_wren_wr", 32'(bus.mem_wren), 0);
        bus.req[0] = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        push(0, 1, 16'h0500, 8'h00, cycle + 3);
        run_req(0, 1, 1'b0, 16'h0500, 8'h00);

        repeat (5) @(negedge clk_sys);
        check("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
